// File: rtl/dot_pkg.sv
// Shared types and helpers for the pipelined dot-product unit.
// Holds the accumulator width formula and the saturating range check.
package dot_pkg;

  localparam int unsigned MAX_SUM_W = 128;

  typedef struct packed {
    logic                 fit;
    logic [MAX_SUM_W-1:0] clamped;
  } sat_res_t;

  // Exact-sum width: full products plus growth for the lane count plus sign.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned lanes);
    return 2 * width + $clog2(lanes) + 1;
  endfunction

  // Range check of a sign-extended sum against a width-bit signed range.
  function automatic sat_res_t sat_fit(input logic signed [MAX_SUM_W-1:0] sum,
                                       input int unsigned width);
    logic        [MAX_SUM_W-1:0] lim;
    logic signed [MAX_SUM_W-1:0] hi;
    logic signed [MAX_SUM_W-1:0] lo;
    sat_res_t                    r;
    lim       = MAX_SUM_W'(1) << (width - 1);
    hi        = $signed(lim - MAX_SUM_W'(1));
    lo        = $signed(~(lim - MAX_SUM_W'(1)));
    r.fit     = 1'b1;
    r.clamped = sum;
    if (sum > hi) begin
      r.fit     = 1'b0;
      r.clamped = hi;
    end else if (sum < lo) begin
      r.fit     = 1'b0;
      r.clamped = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dot_pipe_if.sv
// FIFO-side bus of the dot-product pipe: operand pop port, result push port,
// and the sticky overflow flag with its clear.
interface dot_pipe_if #(
  parameter int unsigned LANES = 3,
  parameter int unsigned WIDTH = 32
);
  logic [LANES-1:0][WIDTH-1:0] x;
  logic [LANES-1:0][WIDTH-1:0] y;
  logic                        in_empty;
  logic                        in_rd_en;
  logic [WIDTH-1:0]            out;
  logic                        out_full;
  logic                        out_wr_en;
  logic                        ovf;
  logic                        ovf_clr;

  modport master (
    output x, y, in_empty, out_full, ovf_clr,
    input  in_rd_en, out, out_wr_en, ovf
  );

  modport slave (
    input  x, y, in_empty, out_full, ovf_clr,
    output in_rd_en, out, out_wr_en, ovf
  );
endinterface

// File: rtl/dot_lane_mul.sv
// One lane of the dot product: registered full-width signed product,
// followed by the arithmetic Q-format shift feeding the adder tree.
module dot_lane_mul #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned Q_BITS = 10
) (
  input  logic                 clock,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   q_c
);
  localparam int unsigned P_W = 2 * WIDTH;

  logic signed [P_W-1:0] p_d;
  logic signed [P_W-1:0] p_q;

  always_comb begin
    p_d = p_q;
    if (en) p_d = P_W'($signed(a)) * P_W'($signed(b));
  end

  always_ff @(posedge clock) begin
    p_q <= p_d;
  end

  // Arithmetic shift floors toward -inf.
  assign q_c = p_q >>> Q_BITS;

endmodule

// File: rtl/dot_pipe.sv
// Three-stage pipelined signed fixed-point dot product between two FWFT FIFOs,
// with optional saturation and a sticky overflow flag.
module dot_pipe
  import dot_pkg::*;
#(
  parameter int unsigned LANES    = 3,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned Q_BITS   = 10,
  parameter bit          SATURATE = 1'b1
) (
  input  logic     clock,
  input  logic     reset,
  dot_pipe_if.slave bus
);
  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned SUM_W = sum_width(WIDTH, LANES);

  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic                    ovf_q, ovf_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    adv1_c, adv2_c, adv3_c;
  logic [P_W-1:0]          lane_q [LANES];
  sat_res_t                sat_c;
  logic                    sat_unused_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dot_lane_mul #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) u_mul (
      .clock (clock),
      .en    (adv1_c),
      .a     (bus.x[i]),
      .b     (bus.y[i]),
      .q_c   (lane_q[i])
    );
  end

  // A stage may load when it is empty or its successor is moving.
  assign adv3_c = !v3_q || !bus.out_full;
  assign adv2_c = !v2_q || adv3_c;
  assign adv1_c = !v1_q || adv2_c;

  assign bus.in_rd_en  = reset && !bus.in_empty && adv1_c;
  assign bus.out_wr_en = reset && v3_q && !bus.out_full;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;

  assign sat_unused_c = ^sat_c.clamped[MAX_SUM_W-1:WIDTH];

  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    sum_d = sum_q;
    out_d = out_q;
    ovf_d = ovf_q;
    sat_c = sat_fit(MAX_SUM_W'(sum_q), WIDTH);

    if (bus.ovf_clr) ovf_d = 1'b0;

    if (adv1_c) v1_d = bus.in_rd_en;

    if (adv2_c) begin
      v2_d  = v1_q;
      sum_d = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        sum_d = sum_d + SUM_W'($signed(lane_q[i]));
      end
    end

    // A new overflow outranks a coincident clear.
    if (adv3_c) begin
      v3_d = v2_q;
      if (v2_q) begin
        out_d = SATURATE ? sat_c.clamped[WIDTH-1:0] : sum_q[WIDTH-1:0];
        if (!sat_c.fit) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sum_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      sum_q <= sum_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dot_pipe.sv
// Bench for dot_pipe: a saturating and a wrapping instance share one stimulus
// stream; results are scored against an integer reference model.
module tb_dot_pipe;
  localparam int unsigned LANES  = 3;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned Q_BITS = 10;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
  typedef struct {
    logic [WIDTH-1:0] sat;
    logic [WIDTH-1:0] wrap;
    bit               ovf;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dot_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) ifs ();
  dot_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) ifw ();

  dot_pipe #(.LANES(LANES), .WIDTH(WIDTH), .Q_BITS(Q_BITS), .SATURATE(1'b1)) dut_s (
    .clock (clock), .reset (reset), .bus (ifs.slave));
  dot_pipe #(.LANES(LANES), .WIDTH(WIDTH), .Q_BITS(Q_BITS), .SATURATE(1'b0)) dut_w (
    .clock (clock), .reset (reset), .bus (ifw.slave));

  assign ifw.x        = ifs.x;
  assign ifw.y        = ifs.y;
  assign ifw.in_empty = ifs.in_empty;
  assign ifw.out_full = ifs.out_full;
  assign ifw.ovf_clr  = ifs.ovf_clr;

  vec_t             src_x[$], src_y[$];
  exp_t             exp_q[$];
  logic [WIDTH-1:0] act_s[$], act_w[$];
  bit               act_ovf[$];
  int               pop_cyc[$], push_cyc[$];
  int               cyc = 0, pops = 0, full_mode = 0;
  bit               pop_pending = 0;
  int               n_checks = 0, n_fail = 0;

  // Reference: exact integer dot product of floored Q-format lane products.
  function automatic exp_t model(vec_t xv, vec_t yv);
    longint sum = 0;
    longint a, b;
    exp_t   e;
    for (int i = 0; i < LANES; i++) begin
      a   = longint'($signed(xv[i]));
      b   = longint'($signed(yv[i]));
      sum = sum + ((a * b) >>> Q_BITS);
    end
    e.wrap = sum[31:0];
    e.ovf  = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
    e.sat  = e.ovf ? ((sum > 0) ? 32'h7FFFFFFF : 32'h80000000) : sum[31:0];
    return e;
  endfunction

  function automatic vec_t mk(logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    vec_t v;
    v[0] = e0; v[1] = e1; v[2] = e2;
    return v;
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
      if ($urandom_range(0, 2) == 0) v[i] = $urandom;
      else v[i] = 32'($signed(16'($urandom)));
    end
    return v;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Upstream FIFO and downstream full driver, updated after each edge.
  always @(posedge clock) begin
    #2;
    if (pop_pending) begin
      void'(src_x.pop_front());
      void'(src_y.pop_front());
      pop_pending = 0;
    end
    ifs.in_empty = (src_x.size() == 0);
    ifs.x        = (src_x.size() == 0) ? '0 : src_x[0];
    ifs.y        = (src_y.size() == 0) ? '0 : src_y[0];
    ifs.out_full = (full_mode == 1) ? 1'b1 :
                   (full_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: record pops into the model queue and pushes into actual queues.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      pop_cyc.delete();
    end
    if (ifs.in_rd_en) begin
      exp_q.push_back(model(ifs.x, ifs.y));
      pop_cyc.push_back(cyc);
      pops = pops + 1;
      pop_pending = 1;
    end
    if (ifs.out_wr_en) begin
      act_s.push_back(ifs.out);
      act_ovf.push_back(ifs.ovf);
      push_cyc.push_back(cyc);
    end
    if (ifw.out_wr_en) act_w.push_back(ifw.out);
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic add_pair(vec_t a, vec_t b);
    src_x.push_back(a);
    src_y.push_back(b);
  endtask

  task automatic wait_pushes(int n, int budget, output bit ok);
    int k = 0;
    while (act_s.size() < n && k < budget) begin
      step(1);
      k++;
    end
    ok = (act_s.size() >= n);
  endtask

  task automatic drain();
    exp_q.delete(); act_s.delete(); act_w.delete();
    act_ovf.delete(); pop_cyc.delete(); push_cyc.delete();
  endtask

  task automatic test_reset();
    add_pair(mk(32'd1, 32'd2, 32'd3), mk(32'd4, 32'd5, 32'd6));
    step(2);
    @(negedge clock);
    n_checks++; if (ifs.in_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", ifs.in_rd_en); end
    n_checks++; if (ifs.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", ifs.out_wr_en); end
    n_checks++; if (ifs.out !== 32'h0) begin n_fail++; $display("FAIL reset_out_s: got %h want 0", ifs.out); end
    n_checks++; if (ifw.out !== 32'h0) begin n_fail++; $display("FAIL reset_out_w: got %h want 0", ifw.out); end
    n_checks++; if (ifs.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ifs.ovf); end
    src_x.delete();
    src_y.delete();
    step(1);
    reset = 1'b1;
    step(3);
    n_checks++; if (act_s.size() != 0) begin n_fail++; $display("FAIL reset_no_push: got %0d want 0", act_s.size()); end
    drain();
  endtask

  task automatic test_basic();
    bit ok;
    add_pair(mk(32'd1024, 32'd2048, -32'sd1024), mk(32'd1024, 32'd512, 32'd1024));
    wait_pushes(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d pushes want 1", act_s.size()); end
    if (ok) begin
      n_checks++; if (act_s[0] !== 32'd1024) begin n_fail++; $display("FAIL basic_out_s: got %h want %h", act_s[0], 32'd1024); end
      n_checks++; if (act_w[0] !== 32'd1024) begin n_fail++; $display("FAIL basic_out_w: got %h want %h", act_w[0], 32'd1024); end
      n_checks++; if (push_cyc[0] - pop_cyc[0] !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", push_cyc[0] - pop_cyc[0]); end
      n_checks++; if (act_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", act_ovf[0]); end
    end
    drain();
  endtask

  task automatic test_floor();
    bit ok;
    add_pair(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), mk(32'd1, 32'd1, 32'd1));
    wait_pushes(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL floor_timeout: got %0d pushes want 1", act_s.size()); end
    if (ok) begin
      n_checks++; if (act_s[0] !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL floor_out_s: got %h want fffffffd", act_s[0]); end
      n_checks++; if (act_w[0] !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL floor_out_w: got %h want fffffffd", act_w[0]); end
      n_checks++; if (act_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL floor_ovf: got %b want 0", act_ovf[0]); end
    end
    drain();
  endtask

  task automatic test_saturation();
    bit ok;
    vec_t pmax, nmax;
    pmax = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    nmax = mk(32'h80000001, 32'h80000001, 32'h80000001);
    add_pair(pmax, pmax);
    add_pair(pmax, nmax);
    wait_pushes(2, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got %0d pushes want 2", act_s.size()); end
    if (ok) begin
      n_checks++; if (act_s[0] !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fffffff", act_s[0]); end
      n_checks++; if (act_w[0] !== 32'hFF400000) begin n_fail++; $display("FAIL wrap_pos: got %h want ff400000", act_w[0]); end
      n_checks++; if (act_s[1] !== 32'h80000000) begin n_fail++; $display("FAIL sat_neg: got %h want 80000000", act_s[1]); end
      n_checks++; if (act_w[1] !== 32'h00BFFFFD) begin n_fail++; $display("FAIL wrap_neg: got %h want 00bffffd", act_w[1]); end
      n_checks++; if (act_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", act_ovf[0]); end
    end
    @(negedge clock);
    n_checks++; if (ifw.ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", ifw.ovf); end
    drain();
    step(1);
    ifs.ovf_clr = 1'b1;
    step(1);
    ifs.ovf_clr = 1'b0;
    @(negedge clock);
    n_checks++; if (ifs.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf_s: got %b want 0", ifs.ovf); end
    n_checks++; if (ifw.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf_w: got %b want 0", ifw.ovf); end
    step(1);
    ifs.ovf_clr = 1'b1;
    add_pair(pmax, pmax);
    wait_pushes(1, 20, ok);
    ifs.ovf_clr = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clrset_timeout: got %0d pushes want 1", act_s.size()); end
    if (ok) begin
      n_checks++; if (act_ovf[0] !== 1'b1) begin n_fail++; $display("FAIL clrset_ovf: got %b want 1", act_ovf[0]); end
    end
    drain();
    step(1);
    ifs.ovf_clr = 1'b1;
    step(1);
    ifs.ovf_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int p0;
    full_mode = 1;
    step(1);
    p0 = pops;
    for (int i = 0; i < 8; i++) add_pair(rvec(), rvec());
    step(10);
    @(negedge clock);
    n_checks++; if (pops - p0 !== 3) begin n_fail++; $display("FAIL bp_pops: got %0d want 3", pops - p0); end
    n_checks++; if (ifs.in_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", ifs.in_rd_en); end
    n_checks++; if (act_s.size() != 0) begin n_fail++; $display("FAIL bp_stall_push: got %0d want 0", act_s.size()); end
    full_mode = 0;
    wait_pushes(8, 40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d pushes want 8", act_s.size()); end
    for (int i = 0; i < act_s.size() && i < exp_q.size(); i++) begin
      n_checks++; if (act_s[i] !== exp_q[i].sat) begin n_fail++; $display("FAIL bp_out_s[%0d]: got %h want %h", i, act_s[i], exp_q[i].sat); end
      n_checks++; if (act_w[i] !== exp_q[i].wrap) begin n_fail++; $display("FAIL bp_out_w[%0d]: got %h want %h", i, act_w[i], exp_q[i].wrap); end
    end
    for (int i = 0; i + 1 < push_cyc.size(); i++) begin
      n_checks++; if (push_cyc[i+1] - push_cyc[i] !== 1) begin n_fail++; $display("FAIL bp_b2b[%0d]: got gap %0d want 1", i, push_cyc[i+1] - push_cyc[i]); end
    end
    drain();
  endtask

  task automatic test_random();
    bit ok;
    full_mode = 2;
    for (int i = 0; i < 1000; i++) add_pair(rvec(), rvec());
    wait_pushes(1000, 20000, ok);
    full_mode = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rnd_timeout: got %0d pushes want 1000", act_s.size()); end
    for (int i = 0; i < act_s.size() && i < exp_q.size(); i++) begin
      n_checks++; if (act_s[i] !== exp_q[i].sat) begin n_fail++; $display("FAIL rnd_out_s[%0d]: got %h want %h", i, act_s[i], exp_q[i].sat); end
      n_checks++; if (act_w[i] !== exp_q[i].wrap) begin n_fail++; $display("FAIL rnd_out_w[%0d]: got %h want %h", i, act_w[i], exp_q[i].wrap); end
    end
    step(6);
    n_checks++; if (act_s.size() != 1000) begin n_fail++; $display("FAIL rnd_count: got %0d want 1000", act_s.size()); end
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int p0;
    exp_t e4;
    vec_t a4, b4;
    full_mode = 1;
    step(1);
    p0 = pops;
    for (int i = 0; i < 3; i++) add_pair(rvec(), rvec());
    a4 = rvec();
    b4 = rvec();
    e4 = model(a4, b4);
    add_pair(a4, b4);
    step(6);
    n_checks++; if (pops - p0 !== 3) begin n_fail++; $display("FAIL rst_fill: got %0d want 3", pops - p0); end
    reset = 1'b0;
    full_mode = 0;
    @(negedge clock);
    n_checks++; if (ifs.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en_during: got %b want 0", ifs.out_wr_en); end
    n_checks++; if (ifs.in_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en_during: got %b want 0", ifs.in_rd_en); end
    step(1);
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (ifs.out !== 32'h0) begin n_fail++; $display("FAIL rst_out_s: got %h want 0", ifs.out); end
    n_checks++; if (ifw.out !== 32'h0) begin n_fail++; $display("FAIL rst_out_w: got %h want 0", ifw.out); end
    n_checks++; if (ifs.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en_after: got %b want 0", ifs.out_wr_en); end
    wait_pushes(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_timeout: got %0d pushes want 1", act_s.size()); end
    if (ok) begin
      n_checks++; if (act_s[0] !== e4.sat) begin n_fail++; $display("FAIL rst_next_s: got %h want %h", act_s[0], e4.sat); end
      n_checks++; if (act_w[0] !== e4.wrap) begin n_fail++; $display("FAIL rst_next_w: got %h want %h", act_w[0], e4.wrap); end
      if (pop_cyc.size() > 0) begin
        n_checks++; if (push_cyc[0] - pop_cyc[0] !== 3) begin n_fail++; $display("FAIL rst_latency: got %0d want 3", push_cyc[0] - pop_cyc[0]); end
      end
    end
    step(6);
    n_checks++; if (act_s.size() != 1) begin n_fail++; $display("FAIL rst_stale: got %0d pushes want 1", act_s.size()); end
    drain();
  endtask

  initial begin
    reset        = 1'b0;
    ifs.x        = '0;
    ifs.y        = '0;
    ifs.in_empty = 1'b1;
    ifs.out_full = 1'b0;
    ifs.ovf_clr  = 1'b0;
    test_reset();
    test_basic();
    test_floor();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
